// File: rtl/digital_output_pkg.sv
// Shared types for the digital output bank: write operations and pulse FSM states.
package digital_output_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_SET    = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_TOGGLE = 2'd3
    } op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } pulse_state_t;

endpackage : digital_output_pkg

// File: rtl/output_pulse_timer.sv
// One-shot pulse timer: a start with a non-zero length holds busy_o for exactly len_i cycles.
module output_pulse_timer
    import digital_output_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             busy_o
);

    pulse_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i && (len_i != '0)) begin
                        state_q <= ST_PULSE;
                        cnt_q   <= len_i;
                    end
                end
                ST_PULSE: begin
                    // Exit on 1, never on 0, so a full-scale length cannot wrap.
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == ST_PULSE);

endmodule : output_pulse_timer

// File: rtl/digital_output_bank.sv
// Bank of digital outputs: a base register updated by bit operations, with a timed
// inversion pulse XORed on top.
module digital_output_bank
    import digital_output_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             write_i,
    input  op_t              op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pulse_i,
    input  logic [WIDTH-1:0] pulse_mask_i,
    input  logic [CNT_W-1:0] pulse_len_i,
    output logic [WIDTH-1:0] data_o,
    output logic             busy_o
);

    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] pmask_q;
    logic             pulse_accept;

    // Same acceptance condition the timer uses, so pmask_q is captured exactly when a pulse starts.
    assign pulse_accept = pulse_i && !busy_o && (pulse_len_i != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q  <= '0;
            pmask_q <= '0;
        end else begin
            if (write_i) begin
                unique case (op_i)
                    OP_WRITE:  base_q <= data_i;
                    OP_SET:    base_q <= base_q | data_i;
                    OP_CLEAR:  base_q <= base_q & ~data_i;
                    OP_TOGGLE: base_q <= base_q ^ data_i;
                    default:   base_q <= base_q;
                endcase
            end
            if (pulse_accept) begin
                pmask_q <= pulse_mask_i;
            end
        end
    end

    output_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (pulse_i),
        .len_i   (pulse_len_i),
        .busy_o  (busy_o)
    );

    assign data_o = base_q ^ (busy_o ? pmask_q : '0);

endmodule : digital_output_bank

// File: tb/tb_digital_output_bank.sv
// Scoreboard bench for digital_output_bank: directed vectors, expected outputs queued per edge.
module tb_digital_output_bank;
    import digital_output_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             write_i;
    op_t              op_i;
    logic [WIDTH-1:0] data_i;
    logic             pulse_i;
    logic [WIDTH-1:0] pulse_mask_i;
    logic [CNT_W-1:0] pulse_len_i;
    logic [WIDTH-1:0] data_o;
    logic             busy_o;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             busy;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    digital_output_bank #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .write_i      (write_i),
        .op_i         (op_i),
        .data_i       (data_i),
        .pulse_i      (pulse_i),
        .pulse_mask_i (pulse_mask_i),
        .pulse_len_i  (pulse_len_i),
        .data_o       (data_o),
        .busy_o       (busy_o)
    );

    task automatic check(input exp_t e);
        checks++;
        if (data_o !== e.data || busy_o !== e.busy) begin
            errors++;
            $display("FAIL %s: got data=%02h busy=%b, expected data=%02h busy=%b",
                     e.name, data_o, busy_o, e.data, e.busy);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the updating edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) check(exp_q.pop_front());
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic cyc(input logic rst, input logic wr, input op_t op, input logic [7:0] d,
                       input logic pl, input logic [7:0] pm, input logic [15:0] len,
                       input logic [7:0] ed, input logic eb, input string name);
        exp_t e;
        @(negedge clk_i);
        rst_i        = rst;
        write_i      = wr;
        op_i         = op;
        data_i       = d;
        pulse_i      = pl;
        pulse_mask_i = pm;
        pulse_len_i  = len;
        @(posedge clk_i);
        e.data = ed;
        e.busy = eb;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [7:0] ed, input logic eb, input string name);
        cyc(1'b0, 1'b0, OP_WRITE, 8'h00, 1'b0, 8'h00, 16'h0000, ed, eb, name);
    endtask

    initial begin
        int wait_cycles;
        rst_i = 1'b1; write_i = 1'b0; op_i = OP_WRITE; data_i = '0;
        pulse_i = 1'b0; pulse_mask_i = '0; pulse_len_i = '0;

        // Reset, then quiet
        cyc(1'b1, 1'b0, OP_WRITE, 8'h00, 1'b0, 8'h00, 16'd0, 8'h00, 1'b0, "reset");
        cyc(1'b1, 1'b0, OP_WRITE, 8'h00, 1'b0, 8'h00, 16'd0, 8'h00, 1'b0, "reset2");
        idle(8'h00, 1'b0, "post_reset");

        // Write operations on consecutive cycles
        cyc(1'b0, 1'b1, OP_WRITE,  8'hA5, 1'b0, 8'h00, 16'd0, 8'hA5, 1'b0, "op_write");
        cyc(1'b0, 1'b1, OP_SET,    8'h0F, 1'b0, 8'h00, 16'd0, 8'hAF, 1'b0, "op_set");
        cyc(1'b0, 1'b1, OP_CLEAR,  8'h81, 1'b0, 8'h00, 16'd0, 8'h2E, 1'b0, "op_clear");
        cyc(1'b0, 1'b1, OP_TOGGLE, 8'hFF, 1'b0, 8'h00, 16'd0, 8'hD1, 1'b0, "op_toggle");
        idle(8'hD1, 1'b0, "hold");
        cyc(1'b0, 1'b1, OP_WRITE,  8'h00, 1'b0, 8'h00, 16'd0, 8'h00, 1'b0, "write_zero");

        // Basic pulse: mask 0x03 for 3 cycles
        cyc(1'b0, 1'b0, OP_WRITE, 8'h00, 1'b1, 8'h03, 16'd3, 8'h03, 1'b1, "pulse3_c1");
        idle(8'h03, 1'b1, "pulse3_c2");
        idle(8'h03, 1'b1, "pulse3_c3");
        idle(8'h00, 1'b0, "pulse3_end");
        idle(8'h00, 1'b0, "pulse3_after");

        // Zero-length pulse is ignored
        cyc(1'b0, 1'b0, OP_WRITE, 8'h00, 1'b1, 8'hFF, 16'd0, 8'h00, 1'b0, "len_zero");
        idle(8'h00, 1'b0, "len_zero_after");

        // Write and retrigger attempt during a pulse
        cyc(1'b0, 1'b0, OP_WRITE, 8'h00, 1'b1, 8'h01, 16'd5, 8'h01, 1'b1, "pulse5_c1");
        idle(8'h01, 1'b1, "pulse5_c2");
        cyc(1'b0, 1'b1, OP_WRITE, 8'hF0, 1'b1, 8'hFF, 16'd9, 8'hF1, 1'b1, "pulse5_c3_write");
        idle(8'hF1, 1'b1, "pulse5_c4");
        idle(8'hF1, 1'b1, "pulse5_c5");
        idle(8'hF0, 1'b0, "pulse5_end");
        idle(8'hF0, 1'b0, "no_retrigger");

        // Empty mask still runs the full pulse
        cyc(1'b0, 1'b0, OP_WRITE, 8'h00, 1'b1, 8'h00, 16'd2, 8'hF0, 1'b1, "mask0_c1");
        idle(8'hF0, 1'b1, "mask0_c2");
        idle(8'hF0, 1'b0, "mask0_end");

        // Write and pulse accepted in the same cycle
        cyc(1'b0, 1'b1, OP_TOGGLE, 8'h0F, 1'b1, 8'h80, 16'd1, 8'h7F, 1'b1, "wr_and_pulse");
        idle(8'hFF, 1'b0, "wr_and_pulse_end");

        // Reset wins over write and pulse
        cyc(1'b1, 1'b1, OP_WRITE, 8'hA5, 1'b1, 8'hFF, 16'd4, 8'h00, 1'b0, "reset_priority");
        idle(8'h00, 1'b0, "reset_priority_after");

        // Reset aborts a running pulse
        cyc(1'b0, 1'b1, OP_WRITE, 8'h55, 1'b0, 8'h00, 16'd0, 8'h55, 1'b0, "base55");
        cyc(1'b0, 1'b0, OP_WRITE, 8'h00, 1'b1, 8'hFF, 16'd10, 8'hAA, 1'b1, "abort_c1");
        idle(8'hAA, 1'b1, "abort_c2");
        cyc(1'b1, 1'b0, OP_WRITE, 8'h00, 1'b0, 8'h00, 16'd0, 8'h00, 1'b0, "abort_reset");
        idle(8'h00, 1'b0, "abort_after");

        // Full-scale pulse length completes without wrapping
        cyc(1'b0, 1'b0, OP_WRITE, 8'h00, 1'b1, 8'h0F, 16'hFFFF, 8'h0F, 1'b1, "max_len_c1");
        for (int i = 2; i <= 65535; i++) idle(8'h0F, 1'b1, "max_len_run");
        idle(8'h00, 1'b0, "max_len_end");
        idle(8'h00, 1'b0, "max_len_after");

        // Drain the scoreboard with a bounded wait
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk_i);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_digital_output_bank

// File: doc/digital_output_bank.md
DIGITAL_OUTPUT_BANK -- requirements
Module: digital_output_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of output channels (1..32).
REQ-002 Parameter CNT_W, default 16, width of the pulse-length counter.
REQ-003 Port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_i  input  1  reset, synchronous, active-high.
REQ-005 Port write_i  input  1  write strobe; one operation per asserted cycle.
REQ-006 Port op_i  input  2  write operation (op_t): WRITE, SET, CLEAR, TOGGLE.
REQ-007 Port data_i  input  WIDTH  write operand: value for WRITE, bit mask for SET/CLEAR/TOGGLE.
REQ-008 Port pulse_i  input  1  pulse start strobe.
REQ-009 Port pulse_mask_i  input  WIDTH  channels inverted during the pulse.
REQ-010 Port pulse_len_i  input  CNT_W  pulse length in clk_i cycles.
REQ-011 Port data_o  output  WIDTH  driven channel values.
REQ-012 Port busy_o  output  1  high while a pulse is in progress.

Function
REQ-013 Block SHALL hold a base register base_q[WIDTH].
- WRITE: base_q <= data_i.
- SET: base_q <= base_q | data_i.
- CLEAR: base_q <= base_q & ~data_i.
- TOGGLE: base_q <= base_q ^ data_i.
REQ-014 data_o SHALL equal base_q ^ (busy_o ? pmask_q : 0); it is a function of registers only, with no combinational path from inputs.
REQ-015 Write latency SHALL be one cycle: the effect of write_i at edge N is visible on data_o after edge N.
REQ-016 With write_i low, base_q SHALL hold; op_i and data_i are don't-care.
REQ-017 FSM SHALL have two states, IDLE and PULSE, with busy_o = (state == PULSE).
REQ-018 IDLE -> PULSE SHALL occur when pulse_i = 1 and pulse_len_i != 0: capture pmask_q <= pulse_mask_i and cnt_q <= pulse_len_i.
REQ-019 In IDLE, pulse_i with pulse_len_i == 0 SHALL be ignored (no state change, no output change).
REQ-020 In PULSE, cnt_q SHALL decrement every cycle; when cnt_q == 1 the next state SHALL be IDLE.
REQ-021 The masked channels SHALL therefore be inverted for exactly pulse_len_i cycles, starting the cycle after acceptance.
REQ-022 pulse_i while busy_o = 1 SHALL be ignored: no retrigger, no extension.
REQ-023 write_i during PULSE SHALL update base_q normally; data_o shows the new base_q XOR pmask_q, and channels revert to the new base_q when the pulse ends.
REQ-024 write_i and pulse_i in the same cycle SHALL both be accepted, independently.
REQ-025 pulse_mask_i == 0 SHALL still run the full pulse (busy_o high for pulse_len_i cycles) with no visible output change.
REQ-026 Maximum pulse_len_i (2^CNT_W - 1) SHALL complete without counter wrap.
REQ-027 op_t values outside the enum cannot occur (2-bit fully encoded); no default action is needed beyond hold.

Reset
REQ-028 rst_i sampled high SHALL force base_q = 0, pmask_q = 0, cnt_q = 0 and state = IDLE, giving data_o = 0 and busy_o = 0 after the edge.
REQ-029 Reset SHALL take priority over write_i and pulse_i in the same cycle.
REQ-030 Reset during PULSE SHALL abort the pulse immediately, with no restore phase.

Structure
REQ-031 Package digital_output_pkg SHALL hold typedef enum logic [1:0] op_t {OP_WRITE = 0, OP_SET = 1, OP_CLEAR = 2, OP_TOGGLE = 3} and the FSM state typedef.
REQ-032 Pulse FSM and counter SHALL live in one sub-module, output_pulse_timer (ports: clk_i, rst_i, start_i, len_i, busy_o).
- The top level owns base_q, pmask_q and the XOR stage.

Verification (WIDTH = 8, CNT_W = 16)
REQ-033 Reset then no stimulus -> data_o = 0x00, busy_o = 0.
REQ-034 WRITE 0xA5, SET 0x0F, CLEAR 0x81, TOGGLE 0xFF on consecutive cycles -> data_o = 0xA5, 0xAF, 0x2E, 0xD1, each one cycle after its strobe.
REQ-035 base = 0x00, pulse mask 0x03 len 3 -> data_o = 0x03 for exactly 3 cycles, then 0x00; busy_o high for the same 3 cycles.
REQ-036 Pulse mask 0x01 len 5; at pulse cycle 2, WRITE 0xF0 and a second pulse_i -> data_o = 0xF1 until the pulse ends, then 0xF0; the second pulse is ignored.
REQ-037 pulse_len_i = 0 -> busy_o stays 0 and data_o is unchanged.
REQ-038 rst_i asserted mid-pulse with base 0x55 -> next cycle data_o = 0x00, busy_o = 0.
